// File: rtl/slice_coeff_sequencer.sv
// Buffers the quantized 8x8 blocks of one slice and replays them to the entropy
// encoders: all DC coefficients first, then AC interleaved across blocks by scan index.
module slice_coeff_sequencer #(
  parameter int BLOCKS_PER_SLICE = 4,
  parameter int COEFF_W          = 20
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [7:0][7:0][31:0]     BLK_DATA,
  input  logic                      BLK_VALID,
  output logic                      BLK_READY,
  output logic                      VLC_RESET,
  output logic signed [COEFF_W-1:0] DC_DATA,
  output logic                      DC_VALID,
  output logic signed [COEFF_W-1:0] AC_DATA,
  output logic                      AC_VALID,
  output logic                      SLICE_DONE,
  output logic                      BUSY
);

  localparam int IDX_W = (BLOCKS_PER_SLICE > 1) ? $clog2(BLOCKS_PER_SLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(BLOCKS_PER_SLICE - 1);
  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF >>> (32 - COEFF_W);
  localparam logic signed [31:0] SAT_MIN = ~SAT_MAX;

  localparam logic [5:0] SCAN [64] = '{
     0,  1,  8,  9,  2,  3, 10, 11,
    16, 17, 24, 25, 18, 19, 26, 27,
     4,  5, 12, 20, 13,  6,  7, 14,
    21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42,
    49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_VRST, S_DC, S_AC, S_DONE} state_t;

  function automatic logic signed [COEFF_W-1:0] sat_coef(input logic signed [31:0] x);
    if (x > SAT_MAX)      sat_coef = SAT_MAX[COEFF_W-1:0];
    else if (x < SAT_MIN) sat_coef = SAT_MIN[COEFF_W-1:0];
    else                  sat_coef = x[COEFF_W-1:0];
  endfunction

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            blk_cnt_q, blk_cnt_d;
  logic [IDX_W-1:0]            blk_idx_q, blk_idx_d;
  logic [5:0]                  scan_idx_q, scan_idx_d;
  logic                        ready_q, ready_d;
  logic                        vlc_q, vlc_d;
  logic                        dcv_q, dcv_d;
  logic                        acv_q, acv_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic signed [COEFF_W-1:0]   dcd_q, dcd_d;
  logic signed [COEFF_W-1:0]   acd_q, acd_d;
  logic signed [COEFF_W-1:0]   sel_coef;
  logic                        accept;

  logic signed [COEFF_W-1:0]   coef_mem_q [BLOCKS_PER_SLICE][64];

  assign accept = BLK_VALID && ready_q;

  // Capture: the whole block lands in slot blk_cnt on the accepting edge
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          coef_mem_q[blk_cnt_q][6'(r*8 + c)] <= sat_coef($signed(BLK_DATA[r][c]));
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    blk_idx_d  = blk_idx_q;
    scan_idx_d = scan_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d    = S_IDLE;
        blk_cnt_d  = '0;
        blk_idx_d  = '0;
        scan_idx_d = '0;
        if (accept) begin
          if (LAST_BLK == '0) begin
            state_d = S_VRST;
          end else begin
            state_d   = S_FILL;
            blk_cnt_d = IDX_W'(1);
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (blk_cnt_q == LAST_BLK) begin
            state_d   = S_VRST;
            blk_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_cnt_q + IDX_W'(1);
          end
        end
      end
      S_VRST: begin
        state_d    = S_DC;
        blk_idx_d  = '0;
        scan_idx_d = '0;
      end
      S_DC: begin
        if (blk_idx_q == LAST_BLK) begin
          state_d    = S_AC;
          blk_idx_d  = '0;
          scan_idx_d = 6'd1;
        end else begin
          blk_idx_d = blk_idx_q + IDX_W'(1);
        end
      end
      S_AC: begin
        if (blk_idx_q == LAST_BLK) begin
          blk_idx_d = '0;
          if (scan_idx_q == 6'd63) begin
            state_d    = S_DONE;
            scan_idx_d = '0;
          end else begin
            scan_idx_d = scan_idx_q + 6'd1;
          end
        end else begin
          blk_idx_d = blk_idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q
    ready_d  = (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_DONE);
    vlc_d    = (state_d != S_VRST);
    dcv_d    = (state_d == S_DC);
    acv_d    = (state_d == S_AC);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d == S_FILL) || (state_d == S_VRST) ||
               (state_d == S_DC)   || (state_d == S_AC);
    sel_coef = coef_mem_q[blk_idx_d][SCAN[scan_idx_d]];
    dcd_d    = dcv_d ? sel_coef : '0;
    acd_d    = acv_d ? sel_coef : '0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      blk_cnt_q  <= '0;
      blk_idx_q  <= '0;
      scan_idx_q <= '0;
      ready_q    <= 1'b0;
      vlc_q      <= 1'b0;
      dcv_q      <= 1'b0;
      acv_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dcd_q      <= '0;
      acd_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_idx_q  <= blk_idx_d;
      scan_idx_q <= scan_idx_d;
      ready_q    <= ready_d;
      vlc_q      <= vlc_d;
      dcv_q      <= dcv_d;
      acv_q      <= acv_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dcd_q      <= dcd_d;
      acd_q      <= acd_d;
    end
  end

  assign BLK_READY  = ready_q;
  assign VLC_RESET  = vlc_q;
  assign DC_VALID   = dcv_q;
  assign AC_VALID   = acv_q;
  assign DC_DATA    = dcd_q;
  assign AC_DATA    = acd_q;
  assign SLICE_DONE = done_q;
  assign BUSY       = busy_q;

endmodule
